// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: flags the last clk cycle of every CLKS_PER_BIT-long bit.
module uart_baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int unsigned       BAUD_W = cnt_w(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] LAST   = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic              bit_end_q;

    always_comb begin
        cnt_d = cnt_q + BAUD_W'(1);
        if (clear_i || bit_end_q) begin
            cnt_d = '0;
        end
    end

    // bit_end is registered from the next count so it lines up with cnt_q == LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= (cnt_d == LAST);
        end
    end

    assign bit_end_o = bit_end_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serializes them as UART frames
// (start, DWIDTH data bits LSB first, optional even parity, 1 or 2 stop bits).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_data_i,
    output logic              fifo_read_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int unsigned      BIT_W     = cnt_w(DWIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DWIDTH - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    uart_state_e       state_q;
    logic [DWIDTH-1:0] shift_q;
    logic              parity_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic bit_end;
    logic last_stop_c;
    logic pop_c;
    logic baud_clear_c;

    assign last_stop_c  = (state_q == STOP) && bit_end && (stop_cnt_q == LAST_STOP);
    assign pop_c        = enable_i && !fifo_empty_i && ((state_q == IDLE) || last_stop_c);
    assign baud_clear_c = (state_q == IDLE) || pop_c;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (baud_clear_c),
        .bit_end_o (bit_end)
    );

    // Frame FSM; a pop in the final stop cycle chains straight into the next START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop_c) begin
                state_q    <= START;
                tx_q       <= 1'b0;
                shift_q    <= fifo_data_i;
                parity_q   <= ^fifo_data_i;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
                busy_q     <= 1'b1;
                done_q     <= (state_q == STOP);
            end else if (bit_end) begin
                unique case (state_q)
                    START: begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= IDLE_LEVEL;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        tx_q    <= IDLE_LEVEL;
                    end
                    STOP: begin
                        if (stop_cnt_q == LAST_STOP) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                        tx_q <= IDLE_LEVEL;
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

    assign fifo_read_o  = pop_c;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small FIFO model feeds two instances
// (parity/1 stop and no-parity/2 stop) and every frame is checked cycle by cycle.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
    logic       sel;
    logic       rd_s, tx_s, busy_s, done_s;

    logic [7:0] mem [16];
    logic [3:0] rd_ptr = 4'd0;
    logic [3:0] wr_ptr = 4'd0;
    logic       empty;
    logic [7:0] fifo_data;
    int         pop_cnt = 0;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         pl;

    always #5 clk = ~clk;

    assign empty     = (rd_ptr == wr_ptr);
    assign fifo_data = mem[rd_ptr];
    assign rd_s      = sel ? rd_b   : rd_a;
    assign tx_s      = sel ? tx_b   : tx_a;
    assign busy_s    = sel ? busy_b : busy_a;
    assign done_s    = sel ? done_b : done_a;

    // FIFO model: pop advances the read pointer on the clock edge.
    always @(posedge clk) begin
        if ((rd_a || rd_b) && !empty) begin
            rd_ptr  <= rd_ptr + 4'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    fifo_uart_tx #(.DWIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (en_a),
        .fifo_empty_i (empty),
        .fifo_data_i  (fifo_data),
        .fifo_read_o  (rd_a),
        .tx_o         (tx_a),
        .busy_o       (busy_a),
        .frame_done_o (done_a)
    );

    fifo_uart_tx #(.DWIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (en_b),
        .fifo_empty_i (empty),
        .fifo_data_i  (fifo_data),
        .fifo_read_o  (rd_b),
        .tx_o         (tx_b),
        .busy_o       (busy_b),
        .frame_done_o (done_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    // Returns positioned in the pop cycle (between negedge and the pop edge).
    task automatic wait_pop(input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (rd_s) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("pop_seen", 32'(found), 32'd1);
    endtask

    // Call in the first cycle of a frame; returns in the cycle after its last stop cycle.
    task automatic frame_check(input logic [7:0] w, input int par_en, input int stops,
                               output bit popped_last);
        logic exp_bits [12];
        int   nb = 0;
        exp_bits[nb++] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[nb++] = w[i];
        if (par_en != 0) exp_bits[nb++] = ^w;
        for (int i = 0; i < stops; i++) exp_bits[nb++] = 1'b1;
        popped_last = 1'b0;
        for (int c = 0; c < nb * 4; c++) begin
            if (c > 0) @(negedge clk);
            check_eq($sformatf("tx_bit%0d", c / 4), 32'(tx_s), 32'(exp_bits[c / 4]));
            check_eq("busy_in_frame", 32'(busy_s), 32'd1);
            if (c > 0) check_eq("done_in_frame", 32'(done_s), 32'd0);
            if (c < nb * 4 - 1) check_eq("no_pop_in_frame", 32'(rd_s), 32'd0);
            else popped_last = rd_s;
        end
        @(negedge clk);
        check_eq("frame_done", 32'(done_s), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b0;
        sel   = 1'b0;

        // Reset with empty FIFO, then idle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) rst_n = 1'b1;
            #1;
            check_eq("rst_tx", 32'(tx_a), 32'd1);
            check_eq("rst_rd", 32'(rd_a), 32'd0);
            check_eq("rst_busy", 32'(busy_a), 32'd0);
            check_eq("rst_done", 32'(done_a), 32'd0);
        end
        check_eq("rst_tx_b", 32'(tx_b), 32'd1);

        // Single word 0xA5.
        push(8'hA5);
        wait_pop(5);
        @(negedge clk);
        frame_check(8'hA5, 1, 1, pl);
        check_eq("a5_no_chain", 32'(pl), 32'd0);
        check_eq("a5_idle_busy", 32'(busy_a), 32'd0);
        check_eq("a5_idle_tx", 32'(tx_a), 32'd1);
        check_eq("a5_pops", 32'(pop_cnt), 32'd1);
        @(negedge clk);
        check_eq("a5_done_once", 32'(done_a), 32'd0);

        // Back-to-back 0x01 then 0xFF.
        push(8'h01);
        push(8'hFF);
        wait_pop(5);
        @(negedge clk);
        frame_check(8'h01, 1, 1, pl);
        check_eq("b2b_chain_pop", 32'(pl), 32'd1);
        frame_check(8'hFF, 1, 1, pl);
        check_eq("b2b_last_no_pop", 32'(pl), 32'd0);
        check_eq("b2b_idle_busy", 32'(busy_a), 32'd0);
        check_eq("b2b_pops", 32'(pop_cnt), 32'd3);

        // enable dropped mid-frame with a second word queued.
        push(8'h3C);
        push(8'h99);
        wait_pop(5);
        @(negedge clk);
        fork
            frame_check(8'h3C, 1, 1, pl);
            begin
                repeat (10) @(negedge clk);
                en_a = 1'b0;
            end
        join
        check_eq("en_no_chain", 32'(pl), 32'd0);
        check_eq("en_idle_busy", 32'(busy_a), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check_eq("en_blocked_rd", 32'(rd_a), 32'd0);
        end
        check_eq("en_pops", 32'(pop_cnt), 32'd4);
        en_a = 1'b1;
        #1;
        check_eq("en_repop", 32'(rd_a), 32'd1);
        @(negedge clk);
        frame_check(8'h99, 1, 1, pl);
        check_eq("en_pops2", 32'(pop_cnt), 32'd5);

        // Reset mid-frame during a data bit of 0x55, then a fresh 0x0F frame.
        push(8'h55);
        wait_pop(5);
        @(negedge clk);
        repeat (17) @(negedge clk);
        check_eq("rstmid_tx_pre", 32'(tx_a), 32'd0);
        check_eq("rstmid_busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_tx", 32'(tx_a), 32'd1);
        check_eq("rstmid_busy", 32'(busy_a), 32'd0);
        check_eq("rstmid_rd", 32'(rd_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(8'h0F);
        wait_pop(5);
        @(negedge clk);
        frame_check(8'h0F, 1, 1, pl);
        check_eq("rstmid_idle_busy", 32'(busy_a), 32'd0);
        check_eq("rstmid_pops", 32'(pop_cnt), 32'd7);

        // Two stop bits, no parity, word 0x80 on the second instance.
        en_a = 1'b0;
        en_b = 1'b1;
        sel  = 1'b1;
        push(8'h80);
        wait_pop(5);
        @(negedge clk);
        frame_check(8'h80, 0, 2, pl);
        check_eq("stop2_no_chain", 32'(pl), 32'd0);
        check_eq("stop2_idle_busy", 32'(busy_b), 32'd0);
        check_eq("stop2_idle_tx", 32'(tx_b), 32'd1);
        check_eq("stop2_a_idle", 32'(tx_a), 32'd1);
        check_eq("stop2_pops", 32'(pop_cnt), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
